mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 34 +++
 rtl/arb_priority.sv | 46 ++++
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// mem_arb_pkg : shared types and sizing helpers for the memory arbiter
// Rev 1.0
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // A single-beat line still needs a 1-bit beat index.
    function automatic int beat_w(input int line_words);
        return (line_words > 1) ? $clog2(line_words) : 1;
    endfunction

    function automatic int off_w(input int line_words);
        return $clog2(line_words * 4);
    endfunction

    function automatic int cnt_w(input int max_cnt);
        return (max_cnt > 0) ? $clog2(max_cnt + 1) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_priority.sv
`default_nettype none
// ============================================================================
// arb_priority : D-first selection with a streak counter that forces I through
// Rev 1.0
// ============================================================================
module arb_priority
    import mem_arb_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic d_req,
    input  logic grant_en,
    output logic pick_i,
    output logic pick_d
);

    localparam int             c_cnt_w = cnt_w(MAX_D_STREAK);
    localparam logic [c_cnt_w-1:0] c_max = c_cnt_w'(MAX_D_STREAK);

    logic [c_cnt_w-1:0] r_streak;
    logic               w_d_ok;

    assign w_d_ok = !i_req || (r_streak < c_max);
    assign pick_d = grant_en && d_req && w_d_ok;
    assign pick_i = grant_en && i_req && !pick_d;

    // Only D grants made while I is waiting extend the streak.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_streak <= '0;
        end else if (pick_d) begin
            if (!i_req) begin
                r_streak <= '0;
            end else if (r_streak != c_max) begin
                r_streak <= r_streak + 1'b1;
            end
        end else if (pick_i) begin
            r_streak <= '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : shares one backing-memory port between I and D line bursts
// Rev 1.0
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int LINE_WORDS   = 4,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_req_i,
    input  logic [ADDR_WIDTH-1:0]           i_addr_i,
    output logic                            i_gnt_o,
    output logic                            i_rvalid_o,
    output logic [DATA_WIDTH-1:0]           i_rdata_o,
    output logic                            i_done_o,
    input  logic                            d_req_i,
    input  logic                            d_we_i,
    input  logic [ADDR_WIDTH-1:0]           d_addr_i,
    input  logic [DATA_WIDTH-1:0]           d_wdata_i,
    output logic [beat_w(LINE_WORDS)-1:0]   d_beat_o,
    output logic                            d_gnt_o,
    output logic                            d_rvalid_o,
    output logic [DATA_WIDTH-1:0]           d_rdata_o,
    output logic                            d_done_o,
    output logic                            mem_req_o,
    output logic                            mem_we_o,
    output logic [ADDR_WIDTH-1:0]           mem_addr_o,
    output logic [DATA_WIDTH-1:0]           mem_wdata_o,
    input  logic                            mem_ack_i,
    input  logic [DATA_WIDTH-1:0]           mem_rdata_i,
    output logic                            busy_o
);

    localparam int                    c_beat_w     = beat_w(LINE_WORDS);
    localparam int                    c_off_w      = off_w(LINE_WORDS);
    localparam logic [c_beat_w-1:0]   c_last_beat  = c_beat_w'(LINE_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] c_align_mask = ~ADDR_WIDTH'((1 << c_off_w) - 1);

    state_e                  r_state;
    owner_e                  r_owner;
    logic [c_beat_w-1:0]     r_beat;
    logic [ADDR_WIDTH-1:0]   r_base;
    logic                    r_we;
    logic                    r_i_gnt;
    logic                    r_d_gnt;
    logic                    r_i_done;
    logic                    r_d_done;
    logic                    r_busy;

    logic                    w_grant_en;
    logic                    w_pick_i;
    logic                    w_pick_d;
    logic                    w_in_burst;
    logic                    w_rd_beat;
    logic [ADDR_WIDTH-1:0]   w_beat_off;

    assign w_grant_en = (r_state == ST_IDLE);
    assign w_in_burst = (r_state == ST_BURST);
    assign w_rd_beat  = w_in_burst && mem_ack_i && !r_we;
    assign w_beat_off = ADDR_WIDTH'(r_beat) << 2;

    arb_priority #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_arb_priority (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req_i),
        .d_req    (d_req_i),
        .grant_en (w_grant_en),
        .pick_i   (w_pick_i),
        .pick_d   (w_pick_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_owner  <= OWN_NONE;
            r_beat   <= '0;
            r_base   <= '0;
            r_we     <= 1'b0;
            r_i_gnt  <= 1'b0;
            r_d_gnt  <= 1'b0;
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_i_gnt  <= 1'b0;
            r_d_gnt  <= 1'b0;
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_d) begin
                        r_owner <= OWN_D;
                        r_base  <= d_addr_i & c_align_mask;
                        r_we    <= d_we_i;
                        r_d_gnt <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= ST_BURST;
                    end else if (w_pick_i) begin
                        r_owner <= OWN_I;
                        r_base  <= i_addr_i & c_align_mask;
                        r_we    <= 1'b0;
                        r_i_gnt <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (mem_ack_i) begin
                        if (r_beat == c_last_beat) begin
                            r_beat   <= '0;
                            r_i_done <= (r_owner == OWN_I);
                            r_d_done <= (r_owner == OWN_D);
                            r_state  <= ST_DONE;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_owner <= OWN_NONE;
                    r_we    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign i_gnt_o     = r_i_gnt;
    assign d_gnt_o     = r_d_gnt;
    assign i_done_o    = r_i_done;
    assign d_done_o    = r_d_done;
    assign busy_o      = r_busy;

    // The memory port is quiet outside BURST so IDLE/DONE never leak stale values.
    assign mem_req_o   = w_in_burst;
    assign mem_we_o    = w_in_burst && r_we;
    assign mem_addr_o  = w_in_burst ? (r_base + w_beat_off) : '0;
    assign mem_wdata_o = w_in_burst ? d_wdata_i : '0;

    assign i_rvalid_o  = w_rd_beat && (r_owner == OWN_I);
    assign i_rdata_o   = i_rvalid_o ? mem_rdata_i : '0;
    assign d_rvalid_o  = w_rd_beat && (r_owner == OWN_D);
    assign d_rdata_o   = d_rvalid_o ? mem_rdata_i : '0;
    assign d_beat_o    = (r_owner == OWN_D) ? r_beat : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : directed and randomized self-checking bench for mem_arbiter
// Rev 1.0
// ============================================================================
module tb_mem_arbiter;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int LW     = 4;
    localparam int MAX_DS = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req_i;
    logic [AW-1:0] i_addr_i;
    logic          i_gnt_o;
    logic          i_rvalid_o;
    logic [DW-1:0] i_rdata_o;
    logic          i_done_o;
    logic          d_req_i;
    logic          d_we_i;
    logic [AW-1:0] d_addr_i;
    logic [DW-1:0] d_wdata_i;
    logic [1:0]    d_beat_o;
    logic          d_gnt_o;
    logic          d_rvalid_o;
    logic [DW-1:0] d_rdata_o;
    logic          d_done_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_ack_i;
    logic [DW-1:0] mem_rdata_i;
    logic          busy_o;

    int checks   = 0;
    int failures = 0;
    int m_streak = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .LINE_WORDS   (LW),
        .MAX_D_STREAK (MAX_DS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_i     (i_req_i),
        .i_addr_i    (i_addr_i),
        .i_gnt_o     (i_gnt_o),
        .i_rvalid_o  (i_rvalid_o),
        .i_rdata_o   (i_rdata_o),
        .i_done_o    (i_done_o),
        .d_req_i     (d_req_i),
        .d_we_i      (d_we_i),
        .d_addr_i    (d_addr_i),
        .d_wdata_i   (d_wdata_i),
        .d_beat_o    (d_beat_o),
        .d_gnt_o     (d_gnt_o),
        .d_rvalid_o  (d_rvalid_o),
        .d_rdata_o   (d_rdata_o),
        .d_done_o    (d_done_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .busy_o      (busy_o)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk1 ({tag, "_i_gnt"},    i_gnt_o,    1'b0);
        chk1 ({tag, "_i_rvalid"}, i_rvalid_o, 1'b0);
        chk32({tag, "_i_rdata"},  i_rdata_o,  32'd0);
        chk1 ({tag, "_i_done"},   i_done_o,   1'b0);
        chk32({tag, "_d_beat"},   32'(d_beat_o), 32'd0);
        chk1 ({tag, "_d_gnt"},    d_gnt_o,    1'b0);
        chk1 ({tag, "_d_rvalid"}, d_rvalid_o, 1'b0);
        chk32({tag, "_d_rdata"},  d_rdata_o,  32'd0);
        chk1 ({tag, "_d_done"},   d_done_o,   1'b0);
        chk1 ({tag, "_mem_req"},  mem_req_o,  1'b0);
        chk1 ({tag, "_mem_we"},   mem_we_o,   1'b0);
        chk32({tag, "_mem_addr"}, mem_addr_o, 32'd0);
        chk32({tag, "_mem_wdata"}, mem_wdata_o, 32'd0);
        chk1 ({tag, "_busy"},     busy_o,     1'b0);
    endtask

    // Called in an IDLE cycle with requests already driven. Predicts the winner from
    // the arbitration rule, then walks the whole burst checking every beat.
    // ack_mode: 0 = ack every cycle, 1 = every 3rd cycle, 2 = random.
    task automatic run_burst(input string tag, input int ack_mode, input bit drop_mid,
                             output bit was_d);
        logic [31:0] base;
        logic [31:0] rd;
        bit          exp_d;
        bit          we;
        bit          ack;
        bit          first;
        int          j;
        int          cyc;

        exp_d = d_req_i && (!i_req_i || m_streak < MAX_DS);
        if (exp_d && i_req_i) m_streak = (m_streak < MAX_DS) ? m_streak + 1 : MAX_DS;
        else                  m_streak = 0;
        base  = (exp_d ? d_addr_i : i_addr_i) & ~32'(LW * 4 - 1);
        we    = exp_d ? d_we_i : 1'b0;
        was_d = exp_d;

        @(posedge clk); #1;
        chk1({tag, "_busy_start"}, busy_o, 1'b1);
        j = 0; cyc = 0; first = 1'b1;
        while (j < LW && cyc < 64) begin
            case (ack_mode)
                0:       ack = 1'b1;
                1:       ack = (cyc % 3 == 2);
                default: ack = ($urandom_range(0, 2) != 0);
            endcase
            rd          = $urandom;
            mem_ack_i   = ack;
            mem_rdata_i = rd;
            d_wdata_i   = $urandom;
            if (drop_mid && j == 1) begin
                if (exp_d) d_req_i = 1'b0;
                else       i_req_i = 1'b0;
            end
            #1;
            chk1 ({tag, "_i_gnt"},    i_gnt_o,     first && !exp_d);
            chk1 ({tag, "_d_gnt"},    d_gnt_o,     first && exp_d);
            chk1 ({tag, "_mem_req"},  mem_req_o,   1'b1);
            chk1 ({tag, "_mem_we"},   mem_we_o,    we);
            chk32({tag, "_mem_addr"}, mem_addr_o,  base + 32'(4 * j));
            chk32({tag, "_mem_wdata"}, mem_wdata_o, d_wdata_i);
            chk32({tag, "_d_beat"},   32'(d_beat_o), exp_d ? 32'(j) : 32'd0);
            chk1 ({tag, "_i_rvalid"}, i_rvalid_o,  ack && !exp_d);
            chk32({tag, "_i_rdata"},  i_rdata_o,   (ack && !exp_d) ? rd : 32'd0);
            chk1 ({tag, "_d_rvalid"}, d_rvalid_o,  ack && exp_d && !we);
            chk32({tag, "_d_rdata"},  d_rdata_o,   (ack && exp_d && !we) ? rd : 32'd0);
            chk1 ({tag, "_i_done_early"}, i_done_o, 1'b0);
            chk1 ({tag, "_d_done_early"}, d_done_o, 1'b0);
            @(posedge clk); #1;
            if (ack) j++;
            cyc++;
            first = 1'b0;
        end
        if (j != LW) begin
            checks++;
            failures++;
            $error("FAIL %s_timeout observed=%0d beats expected=%0d", tag, j, LW);
        end

        // DONE cycle: a stray ack here must be ignored; the owner releases its request.
        mem_ack_i = ($urandom_range(0, 1) == 1);
        if (exp_d) d_req_i = 1'b0;
        else       i_req_i = 1'b0;
        #1;
        chk1 ({tag, "_i_done"},    i_done_o,   !exp_d);
        chk1 ({tag, "_d_done"},    d_done_o,   exp_d);
        chk1 ({tag, "_done_req"},  mem_req_o,  1'b0);
        chk1 ({tag, "_done_busy"}, busy_o,     1'b1);
        chk1 ({tag, "_done_irv"},  i_rvalid_o, 1'b0);
        chk1 ({tag, "_done_drv"},  d_rvalid_o, 1'b0);
        chk32({tag, "_done_beat"}, 32'(d_beat_o), 32'd0);
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
        chk1({tag, "_idle_busy"},   busy_o,    1'b0);
        chk1({tag, "_idle_i_done"}, i_done_o,  1'b0);
        chk1({tag, "_idle_d_done"}, d_done_o,  1'b0);
        chk1({tag, "_idle_req"},    mem_req_o, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit was_d;

        rst = 1'b1;
        i_req_i = 1'b0; i_addr_i = '0;
        d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Plain I-side read with acks every cycle; low address bits ignored.
        i_req_i = 1'b1; i_addr_i = 32'h0000_0104;
        run_burst("t1_iread", 0, 1'b0, was_d);

        // D writeback with slow acks.
        d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h0000_0200;
        run_burst("t2_dwrite", 1, 1'b0, was_d);

        // Simultaneous requests: D first, I immediately after D's DONE/IDLE.
        i_req_i = 1'b1; i_addr_i = 32'h0000_0400;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0000_0510;
        run_burst("t3_first", 0, 1'b0, was_d);
        chk1("t3_order_d", was_d, 1'b1);
        run_burst("t3_second", 0, 1'b0, was_d);

        // Starvation guard: D re-raised after every done while I keeps waiting.
        i_req_i = 1'b1; i_addr_i = 32'h0000_0800;
        for (int k = 0; k < MAX_DS + 2; k++) begin
            d_req_i = 1'b1; d_we_i = k[0]; d_addr_i = 32'h0000_0900 + 32'(k * 16);
            run_burst("t4_streak", 0, 1'b0, was_d);
        end

        // Reset mid-burst aborts without a done pulse.
        i_req_i = 1'b0;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0000_0304;
        @(posedge clk); #1;
        chk1("t5_gnt", d_gnt_o, 1'b1);
        mem_ack_i = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        mem_ack_i = 1'b0;
        #1;
        chk32("t5_beat2", 32'(d_beat_o), 32'd2);
        chk32("t5_addr2", mem_addr_o, 32'h0000_0308);
        rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("t5_abort");
        rst = 1'b0;
        m_streak = 0;
        run_burst("t5_reissue", 0, 1'b0, was_d);

        // Stray acks in IDLE, then a D read whose request drops mid-burst.
        mem_ack_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk1 ("t6_idle_busy", busy_o, 1'b0);
            chk1 ("t6_idle_req",  mem_req_o, 1'b0);
            chk32("t6_idle_beat", 32'(d_beat_o), 32'd0);
        end
        mem_ack_i = 1'b0;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0000_0A0C;
        run_burst("t6_drop", 2, 1'b1, was_d);

        // Randomized traffic; a pending loser holds its request and address.
        for (int n = 0; n < 40; n++) begin
            if (!i_req_i && $urandom_range(0, 1) == 1) begin
                i_req_i = 1'b1; i_addr_i = $urandom;
            end
            if (!d_req_i && $urandom_range(0, 1) == 1) begin
                d_req_i = 1'b1; d_we_i = $urandom_range(0, 1) == 1; d_addr_i = $urandom;
            end
            if (!i_req_i && !d_req_i) begin
                d_req_i = 1'b1; d_we_i = $urandom_range(0, 1) == 1; d_addr_i = 32'hFFFF_FFF4;
            end
            run_burst("rnd", 2, ($urandom_range(0, 7) == 0), was_d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
